// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake
// and a 2-entry skid buffer (main + skid), so in_ready is fully registered.
// Carries a WIDTH-bit payload and a SIDE_W-bit sticky side field.
// Optional feature: define PIPE_STALL_CNT_EN to build a saturating
// stall-cycle counter on stall_cnt (otherwise stall_cnt is tied to 0).
module pipe_stage_skid #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          SIDE_W    = 1,
  parameter logic [WIDTH-1:0]     NOP_VALUE = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_main_valid;
  logic [WIDTH-1:0]  r_main_data;
  logic [SIDE_W-1:0] r_side;
  logic              r_skid_valid;
  logic [WIDTH-1:0]  r_skid_data;
  logic [SIDE_W-1:0] r_skid_side;
  logic              r_in_ready;

  logic              w_main_valid;
  logic [WIDTH-1:0]  w_main_data;
  logic [SIDE_W-1:0] w_side;
  logic              w_skid_valid;
  logic [WIDTH-1:0]  w_skid_data;
  logic [SIDE_W-1:0] w_skid_side;

  logic w_acc;
  logic w_fire;

  assign w_acc  = in_valid & r_in_ready;
  assign w_fire = r_main_valid & out_ready;

  // Next-state selection: flush, then refill main (from skid first, keeping
  // FIFO order), otherwise hold main and park any accepted payload in skid.
  always_comb begin
    w_main_valid = r_main_valid;
    w_main_data  = r_main_data;
    w_side       = r_side;
    w_skid_valid = r_skid_valid;
    w_skid_data  = r_skid_data;
    w_skid_side  = r_skid_side;
    if (flush) begin
      w_main_valid = 1'b0;
      w_main_data  = NOP_VALUE;
      w_side       = '0;
      w_skid_valid = 1'b0;
      w_skid_data  = NOP_VALUE;
      w_skid_side  = '0;
    end else if (!r_main_valid || w_fire) begin
      if (r_skid_valid) begin
        w_main_valid = 1'b1;
        w_main_data  = r_skid_data;
        w_side       = r_skid_side;
        if (w_acc) begin
          w_skid_data = in_data;
          w_skid_side = in_side;
        end else begin
          w_skid_valid = 1'b0;
        end
      end else if (w_acc) begin
        w_main_valid = 1'b1;
        w_main_data  = in_data;
        w_side       = in_side;
      end else begin
        // Bubble: data returns to NOP, side field is sticky and holds.
        w_main_valid = 1'b0;
        w_main_data  = NOP_VALUE;
      end
    end else if (w_acc) begin
      w_skid_valid = 1'b1;
      w_skid_data  = in_data;
      w_skid_side  = in_side;
    end
  end

  // State registers; in_ready is registered from the next skid state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= NOP_VALUE;
      r_side       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_VALUE;
      r_skid_side  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid;
      r_main_data  <= w_main_data;
      r_side       <= w_side;
      r_skid_valid <= w_skid_valid;
      r_skid_data  <= w_skid_data;
      r_skid_side  <= w_skid_side;
      r_in_ready   <= ~w_skid_valid;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_side  = r_side;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count cycles where a valid payload is blocked downstream; saturates,
  // cleared by reset only (flush leaves it alone).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: table-driven cycle vectors plus
// hand-written sequences for synchronous reset and the stall counter.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [0:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [0:0]  out_side;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_data;
  logic [0:0]  s_out_side;
  logic [1:0]  s_stall_cnt;

  int unsigned checks_total;
  int unsigned checks_passed;

  pipe_stage_skid #(.WIDTH(32), .SIDE_W(1), .NOP_VALUE(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_side(out_side), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.WIDTH(32), .SIDE_W(1), .NOP_VALUE(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_side(in_side),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_side(s_out_side), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        is;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_os;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] id,
                     input logic is, input logic ordy, input logic ov, input logic [31:0] od,
                     input logic os, input logic ir);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.is = is; v.ordy = ordy;
    v.e_ov = ov; v.e_od = od; v.e_os = os; v.e_ir = ir;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] id,
                       input logic is, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = id; in_side = is; out_ready = ordy;
  endtask

  logic [31:0] exp_cnt;
  logic [31:0] exp_sat;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //   rst  fl   iv   data    side ordy  ov   od      os   ir
    add(1'b1,1'b0,1'b0,32'h00,1'b0,1'b0, 1'b0,32'h00,1'b0,1'b1); // reset values
    add(1'b0,1'b0,1'b1,32'h01,1'b0,1'b1, 1'b1,32'h01,1'b0,1'b1); // stream
    add(1'b0,1'b0,1'b1,32'h02,1'b0,1'b1, 1'b1,32'h02,1'b0,1'b1);
    add(1'b0,1'b0,1'b1,32'h03,1'b0,1'b1, 1'b1,32'h03,1'b0,1'b1);
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b0,32'h00,1'b0,1'b1); // bubble
    add(1'b0,1'b0,1'b1,32'h0A,1'b0,1'b1, 1'b1,32'h0A,1'b0,1'b1); // main=A
    add(1'b0,1'b0,1'b1,32'h0B,1'b0,1'b0, 1'b1,32'h0A,1'b0,1'b0); // B to skid
    add(1'b0,1'b0,1'b1,32'h0C,1'b0,1'b0, 1'b1,32'h0A,1'b0,1'b0); // full: C ignored
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b1,32'h0B,1'b0,1'b1); // skid->main
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b0,32'h00,1'b0,1'b1); // drained
    add(1'b0,1'b0,1'b1,32'h05,1'b1,1'b1, 1'b1,32'h05,1'b1,1'b1); // side=1
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b0,32'h00,1'b1,1'b1); // sticky on bubble
    add(1'b0,1'b0,1'b1,32'h06,1'b0,1'b1, 1'b1,32'h06,1'b0,1'b1); // side follows entry
    add(1'b0,1'b0,1'b1,32'h07,1'b1,1'b1, 1'b1,32'h07,1'b1,1'b1); // main=7
    add(1'b0,1'b0,1'b1,32'h08,1'b0,1'b0, 1'b1,32'h07,1'b1,1'b0); // skid=8
    add(1'b0,1'b1,1'b1,32'h09,1'b0,1'b0, 1'b0,32'h00,1'b0,1'b1); // flush, ordy=0
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b0,32'h00,1'b0,1'b1); // 8/9 gone
    add(1'b0,1'b0,1'b1,32'h11,1'b1,1'b1, 1'b1,32'h11,1'b1,1'b1);
    add(1'b0,1'b1,1'b1,32'h12,1'b1,1'b1, 1'b0,32'h00,1'b0,1'b1); // flush drops acc
    add(1'b0,1'b0,1'b0,32'h00,1'b0,1'b1, 1'b0,32'h00,1'b0,1'b1);
    add(1'b0,1'b0,1'b1,32'h20,1'b1,1'b1, 1'b1,32'h20,1'b1,1'b1);
    add(1'b0,1'b0,1'b1,32'h21,1'b0,1'b0, 1'b1,32'h20,1'b1,1'b0); // stalled, skid full

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].is, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
      check($sformatf("v%0d out_side", i), {31'b0, out_side}, {31'b0, vecs[i].e_os});
      check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
    end

    // Reset mid-stall must not act before the clock edge.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("prerst out_valid", {31'b0, out_valid}, 32'h1);
    check("prerst out_data", out_data, 32'h20);
    check("prerst in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst out_data", out_data, 32'h0);
    check("rst out_side", {31'b0, out_side}, 32'h0);
    check("rst in_ready", {31'b0, in_ready}, 32'h1);
    check("rst stall_cnt", {16'b0, stall_cnt}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("postrst out_valid", {31'b0, out_valid}, 32'h0);

    // Stall counter: load one payload, then block downstream.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`ifdef PIPE_STALL_CNT_EN
    exp_cnt = 32'd5; exp_sat = 32'd3;
`else
    exp_cnt = 32'd0; exp_sat = 32'd0;
`endif
    check("stall5 cnt", {16'b0, stall_cnt}, exp_cnt);
    check("stall5 sat", {30'b0, s_stall_cnt}, exp_sat);
    @(posedge clk);
    #1;
`ifdef PIPE_STALL_CNT_EN
    exp_cnt = 32'd6;
`endif
    check("stall6 cnt", {16'b0, stall_cnt}, exp_cnt);
    check("stall6 sat", {30'b0, s_stall_cnt}, exp_sat);
    check("stall held data", out_data, 32'h30);
    check("stall held valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain out_valid", {31'b0, out_valid}, 32'h0);
    check("drain cnt hold", {16'b0, stall_cnt}, exp_cnt);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h31, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
`ifdef PIPE_STALL_CNT_EN
    exp_cnt = 32'd7;
`endif
    check("flush keeps cnt", {16'b0, stall_cnt}, exp_cnt);
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    check("flush out_side", {31'b0, out_side}, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
